// File: rtl/tmds_channel_decoder.sv
// One TMDS channel receiver: 10b->8b decode, control-token detect and word alignment.
// Hunts for runs of control tokens and requests deserialiser bit-slips until locked.
module tmds_channel_decoder #(
    parameter int unsigned CTRL_RUN_MIN   = 8,
    parameter int unsigned SEARCH_TIMEOUT = 4096,
    parameter int unsigned SLIP_WAIT      = 16,
    parameter int unsigned LOCK_TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_tmds_word,
    output logic       o_bitslip,
    output logic       o_locked,
    output logic [3:0] o_slip_cnt,
    output logic       o_de,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl
);

    localparam int unsigned RunW  = $clog2(CTRL_RUN_MIN) + 1;
    localparam int unsigned SrchW = $clog2(SEARCH_TIMEOUT) + 1;
    localparam int unsigned WaitW = $clog2(SLIP_WAIT) + 1;
    localparam int unsigned LockW = $clog2(LOCK_TIMEOUT) + 1;

    localparam logic [RunW-1:0]  RunMax   = RunW'(CTRL_RUN_MIN);
    localparam logic [SrchW-1:0] SrchLast = SrchW'(SEARCH_TIMEOUT - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(SLIP_WAIT - 1);
    localparam logic [LockW-1:0] LockLast = LockW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {StSearch, StSlipWait, StLocked} state_e;

    state_e           state_q, state_d;
    logic [RunW-1:0]  run_q, run_d;
    logic [SrchW-1:0] srch_q, srch_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [LockW-1:0] lock_q, lock_d;
    logic [3:0]       slip_cnt_q, slip_cnt_d;
    logic             bitslip_q, bitslip_d;
    logic             run_full;

    logic             is_ctrl;
    logic [1:0]       ctrl_dec;
    logic [7:0]       q_word, d_word;

    logic             s1_tok_q;
    logic [1:0]       s1_ctrl_q;
    logic [7:0]       s1_data_q;
    logic             de_q, de_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       ctrl_q, ctrl_d;

    always_comb begin
        is_ctrl  = 1'b1;
        ctrl_dec = 2'b00;
        case (i_tmds_word)
            10'b1101010100: ctrl_dec = 2'b00;
            10'b0010101011: ctrl_dec = 2'b01;
            10'b0101010100: ctrl_dec = 2'b10;
            10'b1010101011: ctrl_dec = 2'b11;
            default:        is_ctrl  = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        q_word    = i_tmds_word[9] ? ~i_tmds_word[7:0] : i_tmds_word[7:0];
        d_word    = 8'h00;
        d_word[0] = q_word[0];
        for (int i = 1; i < 8; i++) begin
            d_word[i] = i_tmds_word[8] ? (q_word[i] ^ q_word[i-1])
                                       : ~(q_word[i] ^ q_word[i-1]);
        end
    end

    always_comb begin
        run_d = '0;
        if (state_q != StSlipWait && is_ctrl) begin
            run_d = (run_q == RunMax) ? RunMax : run_q + RunW'(1);
        end
    end

    assign run_full = (run_d == RunMax);

    always_comb begin
        state_d    = state_q;
        srch_d     = srch_q;
        wait_d     = wait_q;
        lock_d     = lock_q;
        slip_cnt_d = slip_cnt_q;
        bitslip_d  = 1'b0;
        unique case (state_q)
            StSearch: begin
                if (run_full) begin
                    state_d = StLocked;
                    srch_d  = '0;
                    lock_d  = '0;
                end else if (srch_q == SrchLast) begin
                    bitslip_d  = 1'b1;
                    slip_cnt_d = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
                    state_d    = StSlipWait;
                    wait_d     = '0;
                end else begin
                    srch_d = srch_q + SrchW'(1);
                end
            end
            StSlipWait: begin
                if (wait_q == WaitLast) begin
                    state_d = StSearch;
                    srch_d  = '0;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StLocked: begin
                if (run_full) begin
                    lock_d = '0;
                end else if (lock_q == LockLast) begin
                    state_d = StSearch;
                    srch_d  = '0;
                end else begin
                    lock_d = lock_q + LockW'(1);
                end
            end
            default: state_d = StSearch;
        endcase
    end

    // Stage 2: gate on the current lock state; ctrl holds through data periods.
    always_comb begin
        de_d   = 1'b0;
        data_d = 8'h00;
        ctrl_d = ctrl_q;
        if (!o_locked) begin
            ctrl_d = 2'b00;
        end else if (s1_tok_q) begin
            ctrl_d = s1_ctrl_q;
        end else begin
            de_d   = 1'b1;
            data_d = s1_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StSearch;
            run_q      <= '0;
            srch_q     <= '0;
            wait_q     <= '0;
            lock_q     <= '0;
            slip_cnt_q <= 4'd0;
            bitslip_q  <= 1'b0;
            s1_tok_q   <= 1'b0;
            s1_ctrl_q  <= 2'b00;
            s1_data_q  <= 8'h00;
            de_q       <= 1'b0;
            data_q     <= 8'h00;
            ctrl_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            srch_q     <= srch_d;
            wait_q     <= wait_d;
            lock_q     <= lock_d;
            slip_cnt_q <= slip_cnt_d;
            bitslip_q  <= bitslip_d;
            s1_tok_q   <= is_ctrl;
            s1_ctrl_q  <= ctrl_dec;
            s1_data_q  <= d_word;
            de_q       <= de_d;
            data_q     <= data_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign o_locked   = (state_q == StLocked);
    assign o_bitslip  = bitslip_q;
    assign o_slip_cnt = slip_cnt_q;
    assign o_de       = de_q;
    assign o_data     = data_q;
    assign o_ctrl     = ctrl_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Randomised and directed bench for tmds_channel_decoder against a cycle-level reference model.
module tb_tmds_channel_decoder;

    localparam int RUN_MIN = 8;
    localparam int S_TMO   = 4096;
    localparam int S_WAIT  = 16;
    localparam int L_TMO   = 4096;

    localparam int M_SEARCH = 0;
    localparam int M_WAIT   = 1;
    localparam int M_LOCKED = 2;

    localparam logic [9:0] TOKS [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] tmds_word = 10'h100;
    logic       bitslip, locked, de;
    logic [3:0] slip_cnt;
    logic [7:0] data;
    logic [1:0] ctrl;

    int n_checks = 0;
    int n_fail   = 0;
    int ecount   = 0;
    int cur_edge = 0;

    // Reference model state
    int         m_mode, m_run, m_timer, m_wait, m_slips;
    bit         m_pulse, m_de;
    logic [7:0] m_data;
    logic [1:0] m_ctrl;
    logic [9:0] p_word;

    tmds_channel_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .i_tmds_word (tmds_word),
        .o_bitslip   (bitslip),
        .o_locked    (locked),
        .o_slip_cnt  (slip_cnt),
        .o_de        (de),
        .o_data      (data),
        .o_ctrl      (ctrl)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_tok(input logic [9:0] w, output logic [1:0] c);
        c = 2'b00;
        for (int k = 0; k < 4; k++) begin
            if (TOKS[k] == w) begin
                c = 2'(k);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        logic [7:0] q, d;
        q = w[9] ? ~w[7:0] : w[7:0];
        d = 8'h00;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = w[8] ? (q[i] ^ q[i-1]) : !(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        logic [1:0] c;
        w = 10'(($urandom));
        for (int k = 0; k < 8 && is_tok(w, c); k++) w = 10'(($urandom));
        if (is_tok(w, c)) w = 10'h100;
        return w;
    endfunction

    function automatic logic [31:0] dut_outs();
        return {15'b0, bitslip, locked, slip_cnt, de, data, ctrl};
    endfunction

    function automatic logic [31:0] model_outs();
        return {15'b0, m_pulse, m_mode == M_LOCKED, 4'(m_slips), m_de, m_data, m_ctrl};
    endfunction

    task automatic model_step(input logic [9:0] w, input bit r);
        logic [1:0] c;
        bit tok;
        if (r) begin
            m_mode = M_SEARCH; m_run = 0; m_timer = 0; m_wait = 0; m_slips = 0;
            m_pulse = 0; m_de = 0; m_data = 8'h00; m_ctrl = 2'b00; p_word = 10'h100;
            return;
        end
        // Outputs reflect the word sampled one edge earlier, gated by the pre-edge lock.
        if (m_mode != M_LOCKED) begin
            m_de = 0; m_data = 8'h00; m_ctrl = 2'b00;
        end else if (is_tok(p_word, c)) begin
            m_de = 0; m_data = 8'h00; m_ctrl = c;
        end else begin
            m_de = 1; m_data = ref_decode(p_word);
        end
        p_word  = w;
        m_pulse = 0;
        tok = is_tok(w, c);
        if (m_mode == M_WAIT || !tok) m_run = 0;
        else if (m_run < RUN_MIN) m_run++;
        case (m_mode)
            M_SEARCH: begin
                if (m_run == RUN_MIN) begin
                    m_mode = M_LOCKED; m_timer = 0;
                end else if (m_timer == S_TMO - 1) begin
                    m_pulse = 1; m_slips = (m_slips + 1) % 10; m_mode = M_WAIT; m_wait = 0;
                end else m_timer++;
            end
            M_WAIT: begin
                if (m_wait == S_WAIT - 1) begin
                    m_mode = M_SEARCH; m_timer = 0;
                end else m_wait++;
            end
            default: begin
                if (m_run == RUN_MIN) m_timer = 0;
                else if (m_timer == L_TMO - 1) begin
                    m_mode = M_SEARCH; m_timer = 0;
                end else m_timer++;
            end
        endcase
    endtask

    task automatic step(input logic [9:0] w, input bit r);
        tmds_word = w;
        rst       = r;
        @(posedge clk);
        model_step(w, r);
        if (r) ecount = 0;
        else begin
            cur_edge = ecount;
            ecount++;
        end
        #1;
        check_val("cycle", dut_outs(), model_outs());
    endtask

    task automatic lock_up();
        step(10'h100, 1'b1);
        for (int i = 0; i < RUN_MIN; i++) step(TOKS[$urandom_range(0, 3)], 1'b0);
    endtask

    initial begin
        int pulses[$];
        int fall, slipe, total;

        // Reset state
        step(10'h100, 1'b1);
        step(10'h100, 1'b1);
        check_val("reset_outs", dut_outs(), 32'd0);

        // Lock and latency
        step(10'h354, 1'b1);
        for (int i = 0; i < RUN_MIN; i++) begin
            step(10'h354, 1'b0);
            if (i == RUN_MIN - 2) check_val("lock_early", 32'(locked), 32'd0);
            if (i == RUN_MIN - 1) check_val("lock_rise", 32'(locked), 32'd1);
        end
        step(10'h100, 1'b0);
        check_val("lat_ctrl", {29'b0, de, ctrl}, 32'd0);
        step(10'h100, 1'b0);
        check_val("lat_data", {23'b0, de, data}, 32'h100);
        check_val("no_slip", 32'(bitslip), 32'd0);

        // Decode and ctrl
        step(10'h2FF, 1'b0);
        step(10'h0AB, 1'b0);
        check_val("dec_2ff", {23'b0, de, data}, 32'h1FE);
        step(10'h154, 1'b0);
        check_val("ctrl_01", {29'b0, de, ctrl}, 32'h1);
        step(10'h2AB, 1'b0);
        check_val("ctrl_10", {29'b0, de, ctrl}, 32'h2);
        step(10'h100, 1'b0);
        check_val("ctrl_11", {29'b0, de, ctrl}, 32'h3);
        step(10'h100, 1'b0);
        check_val("ctrl_hold", {29'b0, de, ctrl}, 32'h7);

        // Broken run
        step(10'h100, 1'b1);
        for (int i = 0; i < RUN_MIN - 1; i++) step(TOKS[$urandom_range(0, 3)], 1'b0);
        step(10'h100, 1'b0);
        check_val("broken_nolock", 32'(locked), 32'd0);
        for (int i = 0; i < RUN_MIN; i++) begin
            step(TOKS[$urandom_range(0, 3)], 1'b0);
            if (i == RUN_MIN - 2) check_val("run2_early", 32'(locked), 32'd0);
        end
        check_val("run2_lock", 32'(locked), 32'd1);

        // Slip spacing and wrap
        step(10'h100, 1'b1);
        for (int i = 0; i < 45000 && pulses.size() < 10; i++) begin
            step(10'h100, 1'b0);
            if (bitslip) begin
                pulses.push_back(cur_edge);
                check_val("slip_cnt", 32'(slip_cnt), 32'(pulses.size() % 10));
            end
        end
        check_val("slip_pulses", 32'(pulses.size()), 32'd10);
        if (pulses.size() > 0) check_val("first_slip", 32'(pulses[0]), 32'(S_TMO - 1));
        for (int k = 1; k < pulses.size(); k++)
            check_val("slip_gap", 32'(pulses[k] - pulses[k-1]), 32'(S_TMO + S_WAIT));
        check_val("slip_wrap", 32'(slip_cnt), 32'd0);

        // Lock loss
        lock_up();
        fall  = -1;
        slipe = -1;
        for (int i = 0; i < 9000 && slipe < 0; i++) begin
            step(rand_data(), 1'b0);
            if (fall < 0 && !locked) fall = cur_edge;
            if (fall >= 0 && cur_edge == fall + 1)
                check_val("unlock_gate", {21'b0, de, data, ctrl}, 32'd0);
            if (slipe < 0 && bitslip) slipe = cur_edge;
        end
        check_val("lock_fall", 32'(fall), 32'(RUN_MIN - 1 + L_TMO));
        check_val("loss_slip", 32'(slipe), 32'(RUN_MIN - 1 + L_TMO + S_TMO));
        check_val("loss_cnt", 32'(slip_cnt), 32'd1);

        // Reset mid-lock
        lock_up();
        for (int i = 0; i < 3; i++) step(rand_data(), 1'b0);
        check_val("pre_rst_de", 32'(de), 32'd1);
        step(10'h100, 1'b1);
        check_val("mid_rst", dut_outs(), 32'd0);
        step(10'h354, 1'b0);
        check_val("post_rst_unlocked", 32'(locked), 32'd0);

        // Random bursts of tokens and data, with occasional long data stretches and resets
        total = 0;
        while (total < 16000) begin
            int kind, len;
            kind = $urandom_range(0, 99);
            if (kind < 2) begin
                step(rand_data(), 1'b1);
                len = 1;
            end else if (kind < 6) begin
                len = $urandom_range(3000, 4500);
                for (int i = 0; i < len; i++) step(rand_data(), 1'b0);
            end else if (kind < 55) begin
                len = $urandom_range(1, 12);
                for (int i = 0; i < len; i++) step(TOKS[$urandom_range(0, 3)], 1'b0);
            end else begin
                len = $urandom_range(1, 6);
                for (int i = 0; i < len; i++) step(rand_data(), 1'b0);
            end
            total += len;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
